// File: rtl/cbus_arbiter.sv
// cbus_arbiter: hands the shared memory-side cache bus to one requester for a whole burst.
// Build option: define CBUS_ARB_ROUND_ROBIN_EN for round-robin; default is lowest-index-wins.
package cbus_pkg;
   typedef enum logic [3:0] {
      MLEN1  = 4'd0,
      MLEN2  = 4'd1,
      MLEN4  = 4'd3,
      MLEN8  = 4'd7,
      MLEN16 = 4'd15
   } cbus_len_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      cbus_len_t   len;
      logic        burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   localparam int REQ_W  = $bits(cbus_req_t);
   localparam int RESP_W = $bits(cbus_resp_t);
endpackage

module cbus_arbiter
   import cbus_pkg::*;
#(
   parameter int NUM_INPUTS = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_INPUTS-1:0][REQ_W-1:0]  ireqs,
   output logic [NUM_INPUTS-1:0][RESP_W-1:0] iresps,
   output logic [REQ_W-1:0]                  oreq,
   input  logic [RESP_W-1:0]                 oresp
);
   localparam int GRANT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state_q, state_d;
   logic [GRANT_W-1:0]    grant_q, grant_d;
   logic [GRANT_W-1:0]    win_idx;
   logic [NUM_INPUTS-1:0] req_valid;
   logic [NUM_INPUTS-1:0] pick_vec;
   logic                  any_valid;
   logic                  resp_ready;
   logic                  resp_last;

   // valid and ready/last are the leading fields of their packed structs
   assign resp_ready = oresp[RESP_W-1];
   assign resp_last  = oresp[RESP_W-2];
   assign any_valid  = |req_valid;

   for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_valid
      assign req_valid[gi] = ireqs[gi][REQ_W-1];
   end

`ifdef CBUS_ARB_ROUND_ROBIN_EN
   logic [GRANT_W-1:0]    last_grant_q, last_grant_d;
   logic [NUM_INPUTS-1:0] above_last;

   // Inputs strictly above the last winner get first pick; otherwise wrap to the bottom.
   for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_above
      assign above_last[gi] = req_valid[gi] && (GRANT_W'(gi) > last_grant_q);
   end

   assign pick_vec     = (|above_last) ? above_last : req_valid;
   assign last_grant_d = (state_q == IDLE && any_valid) ? win_idx : last_grant_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= '0;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   assign pick_vec = req_valid;
`endif

   always_comb begin
      win_idx = '0;
      for (int j = NUM_INPUTS - 1; j >= 0; j--) begin
         if (pick_vec[j]) begin
            win_idx = GRANT_W'(j);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      oreq    = '0;
      iresps  = '0;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               state_d = BUSY;
               grant_d = win_idx;
            end
         end
         BUSY: begin
            oreq            = ireqs[grant_q];
            iresps[grant_q] = oresp;
            if (resp_ready && resp_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end
endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed testbench for cbus_arbiter; expectations follow CBUS_ARB_ROUND_ROBIN_EN when defined.
module tb_cbus_arbiter;
   import cbus_pkg::*;

   logic clk = 1'b0;
   logic reset;
   cbus_req_t  rq [2];
   cbus_resp_t rsp;
   cbus_resp_t ir [2];
   cbus_req_t  oreq_s;

   logic [1:0][REQ_W-1:0]  ireqs;
   logic [1:0][RESP_W-1:0] iresps;
   logic [REQ_W-1:0]       oreq;
   logic [RESP_W-1:0]      oresp;

   int checks = 0;
   int errors = 0;

   assign ireqs[0] = rq[0];
   assign ireqs[1] = rq[1];
   assign oresp    = rsp;
   assign ir[0]    = cbus_resp_t'(iresps[0]);
   assign ir[1]    = cbus_resp_t'(iresps[1]);
   assign oreq_s   = cbus_req_t'(oreq);

   always #5 clk = ~clk;

   cbus_arbiter #(.NUM_INPUTS(2)) dut (
      .clk    (clk),
      .reset  (reset),
      .ireqs  (ireqs),
      .iresps (iresps),
      .oreq   (oreq),
      .oresp  (oresp)
   );

   function automatic cbus_req_t make_req(input logic [31:0] addr, input logic wr, input cbus_len_t len);
      cbus_req_t r;
      r.valid    = 1'b1;
      r.is_write = wr;
      r.size     = 3'd2;
      r.addr     = addr;
      r.strobe   = wr ? 4'hF : 4'h0;
      r.data     = 32'hD000_0000 ^ addr;
      r.len      = len;
      r.burst    = (len != MLEN1);
      return r;
   endfunction

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset;
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      rq[0] = '0;
      rq[1] = '0;
      rsp   = '0;
      repeat (3) next_cycle();
      rsp = '{ready: 1'b1, last: 1'b1, data: 32'hFFFF_FFFF};
      @(negedge clk);
      checks++;
      if (oreq !== '0) begin errors++; $display("FAIL reset_oreq got=%h exp=0", oreq); end
      checks++;
      if (iresps !== '0) begin errors++; $display("FAIL reset_iresps got=%h exp=0", iresps); end
      $display("test_reset: oreq=%h iresps=%h", oreq, iresps);
      reset = 1'b0;
      rsp   = '0;
      next_cycle();
   endtask

   task automatic test_single_burst;
      cbus_req_t exp;
      int beat;
      exp   = make_req(32'h8000_0000, 1'b0, MLEN16);
      rq[0] = exp;
      @(negedge clk);
      checks++;
      if (oreq_s.valid !== 1'b0) begin errors++; $display("FAIL single_latency got=%b exp=0", oreq_s.valid); end
      next_cycle();
      beat = 0;
      for (int c = 0; c < 17; c++) begin
         if (c == 5) begin
            rsp = '{ready: 1'b0, last: 1'b0, data: 32'h0BAD_0BAD};
         end else begin
            rsp = '{ready: 1'b1, last: (beat == 15), data: 32'hA5A5_0000 + beat};
            beat++;
         end
         @(negedge clk);
         checks++;
         if (oreq_s !== exp) begin errors++; $display("FAIL single_oreq c=%0d got=%h exp=%h", c, oreq_s, exp); end
         checks++;
         if (ir[0] !== rsp) begin errors++; $display("FAIL single_iresp0 c=%0d got=%h exp=%h", c, ir[0], rsp); end
         checks++;
         if (ir[1] !== '0) begin errors++; $display("FAIL single_iresp1 c=%0d got=%h exp=0", c, ir[1]); end
         next_cycle();
      end
      rq[0] = '0;
      rsp   = '{ready: 1'b1, last: 1'b1, data: 32'h1234_5678};
      @(negedge clk);
      checks++;
      if (oreq_s.valid !== 1'b0) begin errors++; $display("FAIL single_idle_after got=%b exp=0", oreq_s.valid); end
      checks++;
      if (ir[0] !== '0) begin errors++; $display("FAIL single_idle_iresp got=%h exp=0", ir[0]); end
      $display("test_single_burst: 16 beats addr=%h", exp.addr);
      rsp = '0;
      next_cycle();
   endtask

   task automatic test_priority;
      cbus_req_t r [2];
      int first, second;
      pulse_reset();
      r[0] = make_req(32'h1000_0000, 1'b1, MLEN2);
      r[1] = make_req(32'h2000_0000, 1'b0, MLEN2);
`ifdef CBUS_ARB_ROUND_ROBIN_EN
      first = 1;
`else
      first = 0;
`endif
      second = 1 - first;
      rq[0] = r[0];
      rq[1] = r[1];
      @(negedge clk);
      checks++;
      if (oreq_s.valid !== 1'b0) begin errors++; $display("FAIL prio_idle got=%b exp=0", oreq_s.valid); end
      next_cycle();
      for (int t = 0; t < 2; t++) begin
         int w;
         w = (t == 0) ? first : second;
         for (int b = 0; b < 2; b++) begin
            rsp = '{ready: 1'b1, last: (b == 1), data: 32'hC0DE_0000 + 16 * t + b};
            @(negedge clk);
            checks++;
            if (oreq_s !== r[w]) begin errors++; $display("FAIL prio_oreq t=%0d got=%h exp=%h", t, oreq_s, r[w]); end
            checks++;
            if (ir[w] !== rsp) begin errors++; $display("FAIL prio_iresp_win t=%0d got=%h exp=%h", t, ir[w], rsp); end
            checks++;
            if (ir[1 - w] !== '0) begin errors++; $display("FAIL prio_iresp_lose t=%0d got=%h exp=0", t, ir[1 - w]); end
            next_cycle();
         end
         rq[w] = '0;
         rsp   = '0;
         @(negedge clk);
         checks++;
         if (oreq_s.valid !== 1'b0) begin errors++; $display("FAIL prio_gap t=%0d got=%b exp=0", t, oreq_s.valid); end
         $display("test_priority: transaction %0d granted input %0d", t, w);
         next_cycle();
      end
   endtask

   task automatic test_preempt;
      cbus_req_t a, b, bd;
      a  = make_req(32'h3000_0100, 1'b0, MLEN1);
      b  = make_req(32'h4000_0200, 1'b1, MLEN8);
      bd = b;
      bd.valid = 1'b0;
      rq[1] = b;
      @(negedge clk);
      next_cycle();
      for (int c = 0; c < 6; c++) begin
         if (c == 1) rq[0] = a;
         if (c == 3) rq[1] = bd;
         rsp = '{ready: (c != 1 && c != 4), last: (c == 5), data: 32'hBEEF_0000 + c};
         @(negedge clk);
         checks++;
         if (oreq_s !== ((c >= 3) ? bd : b)) begin errors++; $display("FAIL preempt_oreq c=%0d got=%h exp=%h", c, oreq_s, (c >= 3) ? bd : b); end
         checks++;
         if (ir[1] !== rsp) begin errors++; $display("FAIL preempt_iresp1 c=%0d got=%h exp=%h", c, ir[1], rsp); end
         checks++;
         if (ir[0] !== '0) begin errors++; $display("FAIL preempt_wait c=%0d got=%h exp=0", c, ir[0]); end
         next_cycle();
      end
      rq[1] = '0;
      rsp   = '{ready: 1'b1, last: 1'b1, data: 32'h5555_AAAA};
      @(negedge clk);
      checks++;
      if (oreq_s.valid !== 1'b0) begin errors++; $display("FAIL preempt_gap got=%b exp=0", oreq_s.valid); end
      checks++;
      if (ir[0] !== '0) begin errors++; $display("FAIL preempt_gap_iresp got=%h exp=0", ir[0]); end
      next_cycle();
      rsp = '{ready: 1'b1, last: 1'b1, data: 32'h0000_0A0A};
      @(negedge clk);
      checks++;
      if (oreq_s !== a) begin errors++; $display("FAIL preempt_next_oreq got=%h exp=%h", oreq_s, a); end
      checks++;
      if (ir[0] !== rsp) begin errors++; $display("FAIL preempt_next_iresp got=%h exp=%h", ir[0], rsp); end
      $display("test_preempt: input 1 held bus, input 0 granted afterward");
      next_cycle();
      rq[0] = '0;
      rsp   = '0;
      next_cycle();
   endtask

   task automatic test_reset_mid;
      cbus_req_t m, f;
      m = make_req(32'h8000_0040, 1'b0, MLEN16);
      f = make_req(32'h9000_0080, 1'b1, MLEN2);
      rq[0] = m;
      @(negedge clk);
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         rsp = '{ready: 1'b1, last: 1'b0, data: 32'h7000_0000 + c};
         @(negedge clk);
         checks++;
         if (ir[0] !== rsp) begin errors++; $display("FAIL rstmid_beat c=%0d got=%h exp=%h", c, ir[0], rsp); end
         next_cycle();
      end
      reset = 1'b1;
      rsp   = '{ready: 1'b1, last: 1'b0, data: 32'h7000_0003};
      next_cycle();
      rsp = '{ready: 1'b1, last: 1'b1, data: 32'h7000_000F};
      @(negedge clk);
      checks++;
      if (oreq_s.valid !== 1'b0) begin errors++; $display("FAIL rstmid_oreq got=%b exp=0", oreq_s.valid); end
      checks++;
      if (iresps !== '0) begin errors++; $display("FAIL rstmid_iresps got=%h exp=0", iresps); end
      next_cycle();
      reset = 1'b0;
      rq[0] = f;
      @(negedge clk);
      checks++;
      if (ir[0] !== '0) begin errors++; $display("FAIL rstmid_no_last got=%h exp=0", ir[0]); end
      next_cycle();
      for (int c = 0; c < 2; c++) begin
         rsp = '{ready: 1'b1, last: (c == 1), data: 32'h6000_0000 + c};
         @(negedge clk);
         checks++;
         if (oreq_s !== f) begin errors++; $display("FAIL rstmid_fresh_oreq c=%0d got=%h exp=%h", c, oreq_s, f); end
         checks++;
         if (ir[0] !== rsp) begin errors++; $display("FAIL rstmid_fresh_iresp c=%0d got=%h exp=%h", c, ir[0], rsp); end
         next_cycle();
      end
      rq[0] = '0;
      rsp   = '0;
      @(negedge clk);
      checks++;
      if (oreq_s.valid !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", oreq_s.valid); end
      $display("test_reset_mid: abort after 3 beats, fresh request completed");
      next_cycle();
   endtask

   task automatic test_fairness;
      cbus_req_t r [2];
      int exp_idx;
      r[0] = make_req(32'hA000_0000, 1'b0, MLEN1);
      r[1] = make_req(32'hB000_0000, 1'b0, MLEN1);
      pulse_reset();
      rq[1] = r[1];
      next_cycle();
      rsp = '{ready: 1'b1, last: 1'b1, data: 32'h0};
      @(negedge clk);
      checks++;
      if (oreq_s !== r[1]) begin errors++; $display("FAIL fair_prelude got=%h exp=%h", oreq_s, r[1]); end
      next_cycle();
      rq[0] = r[0];
      for (int t = 0; t < 4; t++) begin
`ifdef CBUS_ARB_ROUND_ROBIN_EN
         exp_idx = t % 2;
`else
         exp_idx = 0;
`endif
         rsp = '0;
         @(negedge clk);
         checks++;
         if (oreq_s.valid !== 1'b0) begin errors++; $display("FAIL fair_idle t=%0d got=%b exp=0", t, oreq_s.valid); end
         next_cycle();
         rsp = '{ready: 1'b1, last: 1'b1, data: 32'hF000_0000 + t};
         @(negedge clk);
         checks++;
         if (oreq_s.addr !== r[exp_idx].addr) begin errors++; $display("FAIL fair_grant t=%0d got=%h exp=%h", t, oreq_s.addr, r[exp_idx].addr); end
         checks++;
         if (ir[exp_idx] !== rsp) begin errors++; $display("FAIL fair_iresp t=%0d got=%h exp=%h", t, ir[exp_idx], rsp); end
         $display("test_fairness: transaction %0d addr=%h", t, oreq_s.addr);
         next_cycle();
      end
      rq[0] = '0;
      rq[1] = '0;
      rsp   = '0;
      next_cycle();
   endtask

   initial begin
      reset = 1'b1;
      rq[0] = '0;
      rq[1] = '0;
      rsp   = '0;
      #1;
      test_reset();
      test_single_burst();
      test_priority();
      test_preempt();
      test_reset_mid();
      test_fairness();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 2, giving the number of cache-bus requesters (index 0 = instruction cache, index 1 = data cache).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port ireqs, input, NUM_INPUTS x cbus_req_t: per-requester burst requests.
REQ-005 The block SHALL have port iresps, output, NUM_INPUTS x cbus_resp_t: per-requester responses.
REQ-006 The block SHALL have port oreq, output, cbus_req_t: request to the shared memory-side cache bus.
REQ-007 The block SHALL have port oresp, input, cbus_resp_t: response from the shared memory-side cache bus.

Function
REQ-008 The block SHALL implement two states: IDLE and BUSY, plus a registered grant index of width max(1, clog2(NUM_INPUTS)).
REQ-009 In IDLE, when any ireqs[i].valid=1, the block SHALL select one winner per REQ-019/020, latch its index, and enter BUSY on the next edge.
REQ-010 In IDLE, oreq SHALL be all-zero (valid=0) and every iresps[i] SHALL be all-zero.
REQ-011 In BUSY, oreq SHALL equal ireqs[grant] combinationally, all fields unmodified (is_write, size, addr, strobe, data, len, burst).
REQ-012 In BUSY, iresps[grant] SHALL equal oresp; every other iresps[j] SHALL be all-zero (ready=0, last=0, data=0).
REQ-013 In BUSY, the block SHALL return to IDLE on the edge where oresp.ready=1 and oresp.last=1; no other event SHALL end BUSY.
REQ-014 The grant index SHALL NOT change while in BUSY; requests arriving on other inputs SHALL wait with no response.
REQ-015 Request-to-oreq.valid latency SHALL be exactly 1 cycle from IDLE; one IDLE cycle SHALL separate consecutive transactions, including back-to-back requests from the same input.
REQ-016 If the granted requester drops valid before last beat, the block SHALL remain BUSY (oreq.valid follows the input, i.e. 0) until oresp.ready and oresp.last are both 1; the requester owns that protocol violation.
REQ-017 oresp.ready=1 with last=0 SHALL only forward the beat; the block SHALL count nothing and SHALL rely solely on last.
REQ-018 A request whose valid rises in the same cycle the previous transaction's last beat completes SHALL be considered in the following IDLE cycle, not earlier.
REQ-019 Winner selection SHALL consider only inputs with valid=1 and SHALL always pick exactly one when at least one is valid.
REQ-020 Priority order SHALL be as defined in REQ-023/REQ-024.

Reset
REQ-021 While reset=1 on a clock edge, the block SHALL enter IDLE, set grant=0, and set the round-robin pointer (if present) to 0.
REQ-022 Reset asserted mid-transaction SHALL abort it: from the next cycle oreq.valid=0 and all iresps zero; no last beat is forwarded afterward.

Configuration
REQ-023 With macro CBUS_ARB_ROUND_ROBIN_EN defined, the block SHALL keep a pointer last_grant updated on each IDLE->BUSY transition, and SHALL pick the first valid input scanning from last_grant+1 upward, wrapping modulo NUM_INPUTS.
REQ-024 Without CBUS_ARB_ROUND_ROBIN_EN, the block SHALL use fixed priority: lowest valid index wins; no pointer register SHALL exist.

Verification
REQ-025 Reset, then ireqs[0]: valid=1, addr=0x8000_0000, len=MLEN16, read -> oreq.valid=1 one cycle later with identical fields; 16 oresp.ready beats, last on 16th -> iresps[0] mirrors all 16; IDLE next cycle.
REQ-026 ireqs[0] and ireqs[1] valid in same cycle, both held -> without macro: input 0 served, then input 1; with macro after reset (pointer 0): input 1 first, then input 0.
REQ-027 Input 1 in BUSY, input 0 raises valid mid-burst -> iresps[0] stays zero, oreq fields stay from input 1 until last; input 0 granted after one IDLE cycle.
REQ-028 Reset asserted after beat 3 of a 16-beat transaction -> next cycle oreq.valid=0, iresps all zero; a fresh request then completes normally.
REQ-029 Input 0 continuously valid with macro defined, input 1 valid throughout -> grants alternate 0,1,0,1 over four transactions; without macro input 1 is never granted.
